// File: rtl/mode_sequencer_if.sv
// Front-panel pulse inputs and datapath control outputs of the mode sequencer.
// The master side drives the pulses; the slave side is the sequencer itself.
interface mode_sequencer_if;
   logic       start_f;
   logic       start_t;
   logic       stop_f_t;
   logic       update;
   logic [2:0] prog;
   logic       fib_done;
   logic       tmr_done;
   logic       fib_clr;
   logic       tmr_load;
   logic       fib_en;
   logic       tmr_en;
   logic [1:0] mode;
   logic [2:0] prog_q;
   logic [5:0] led;

   modport master (
      output start_f, start_t, stop_f_t, update, prog, fib_done, tmr_done,
      input  fib_clr, tmr_load, fib_en, tmr_en, mode, prog_q, led
   );

   modport slave (
      input  start_f, start_t, stop_f_t, update, prog, fib_done, tmr_done,
      output fib_clr, tmr_load, fib_en, tmr_en, mode, prog_q, led
   );
endinterface

// File: rtl/mode_sequencer.sv
// Selects the Fibonacci or timer datapath, issues entry clear/load pulses and
// paces the running datapath with a tick every (prog_q+1)*TICK_DIV cycles.
module mode_sequencer #(
   parameter int TICK_DIV = 10
) (
   input  logic             clk,
   input  logic             rst,
   mode_sequencer_if.slave  bus
);

   // Encodings double as the mode output value.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FIB  = 2'b01,
      TMR  = 2'b10
   } state_t;

   // cnt never exceeds limit-1 <= 8*TICK_DIV-1; limit itself needs one value more.
   localparam int CNT_W = $clog2(8 * TICK_DIV);
   localparam int LIM_W = $clog2(8 * TICK_DIV + 1);

   state_t             state_q, state_d;
   logic [2:0]         prog_q, prog_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               fib_clr_q, fib_clr_d;
   logic               tmr_load_q, tmr_load_d;
   logic [LIM_W-1:0]   limit;
   logic [LIM_W-1:0]   limit_m1;
   logic               at_wrap;

   assign limit    = (LIM_W'(prog_q) + LIM_W'(1)) * LIM_W'(TICK_DIV);
   assign limit_m1 = limit - LIM_W'(1);
   assign at_wrap  = (LIM_W'(cnt_q) == limit_m1);

   // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      prog_d     = prog_q;
      fib_clr_d  = 1'b0;
      tmr_load_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.update) prog_d = bus.prog;
            if (bus.start_f) begin
               state_d   = FIB;
               fib_clr_d = 1'b1;
            end else if (bus.start_t) begin
               state_d    = TMR;
               tmr_load_d = 1'b1;
            end
         end
         FIB: begin
            if (bus.stop_f_t || bus.fib_done) state_d = IDLE;
         end
         TMR: begin
            if (bus.stop_f_t || bus.tmr_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Prescaler restarts on every entry and stays parked at zero while idle.
   always_comb begin
      cnt_d = '0;
      if (state_q != IDLE && state_d != IDLE && !at_wrap)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prog_q     <= 3'b000;
         cnt_q      <= '0;
         fib_clr_q  <= 1'b0;
         tmr_load_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prog_q     <= prog_d;
         cnt_q      <= cnt_d;
         fib_clr_q  <= fib_clr_d;
         tmr_load_q <= tmr_load_d;
      end
   end

   assign bus.fib_clr  = fib_clr_q;
   assign bus.tmr_load = tmr_load_q;
   assign bus.fib_en   = (state_q == FIB) && at_wrap;
   assign bus.tmr_en   = (state_q == TMR) && at_wrap;
   assign bus.mode     = state_q;
   assign bus.prog_q   = prog_q;
   assign bus.led      = {state_q == TMR, state_q == FIB, state_q == IDLE, prog_q};

endmodule
